pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central sequencing unit for the 5-stage pipelined MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB latches).
- Decides every cycle which latches advance, hold (freeze) or take a bubble (flush), and whether PC loads.
- Covers cache stalls, load-use hazards, branch-mispredict recovery and halt draining.
- Keeps branch/mispredict statistics counters for the branch-predictor evaluation.

Parameters:
- DRAIN_CYCLES, 2, non-stalled cycles after halt leaves EX before halt output asserts (EX->MEM->WB).
- CNT_W, 32, width of statistics counters.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  icache delivers valid instruction this cycle.
- dhit  in  1  dcache completes MEM-stage access this cycle.
- exmem_dREN  in  1  MEM stage holds a load.
- exmem_dWEN  in  1  MEM stage holds a store.
- idex_dREN  in  1  EX stage holds a load.
- idex_rt  in  5  EX load destination register.
- ifid_rs  in  5  ID source register rs.
- ifid_rt  in  5  ID source register rt.
- ifid_uses_rt  in  1  ID instruction reads rt.
- ex_br_valid  in  1  EX holds a branch/jump resolved this cycle.
- ex_mispredict  in  1  EX resolution differs from fetch-time prediction (direction or target).
- ex_halt  in  1  EX holds HALT.
- pc_en  out  1  PC register loads next value.
- redirect  out  1  PC selects EX-resolved correct target.
- ifid_freeze, idex_freeze, exmem_freeze, memwb_freeze  out  1 each  latch holds contents.
- ifid_flush, idex_flush, exmem_flush  out  1 each  latch loads bubble on the next edge.
- halt  out  1  core halted.
- branch_cnt  out  CNT_W  resolved branches/jumps.
- mispredict_cnt  out  CNT_W  mispredicts.

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Registered: state, 2-bit drain counter, two stat counters. All strobes are combinational from state and inputs.
- Reset (nRST low, async): state=RUN, drain counter=0, counters=0, halt=0.
- dstall = (exmem_dREN | exmem_dWEN) & ~dhit.
- RUN priority, highest first:
  1. dstall: all four freezes=1, pc_en=0, no flush, no redirect, counters hold.
  2. ex_br_valid & ex_mispredict: redirect=1, pc_en=1 (ihit ignored; stale fetch abandoned), ifid_flush=1, idex_flush=1, EX/MEM and MEM/WB advance.
  3. Load-use: idex_dREN & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)). Effect: pc_en=0, ifid_freeze=1, idex_flush=1, EX/MEM and MEM/WB advance.
  4. ~ihit: pc_en=0, ifid_flush=1, downstream advance.
  5. Otherwise: pc_en=1, nothing frozen or flushed.
- Counters: in RUN only, on a non-dstall cycle. ex_br_valid increments branch_cnt; ex_br_valid & ex_mispredict also increments mispredict_cnt. Both saturate at all-ones.
- RUN->DRAIN: ex_halt & ~dstall. Drain counter loads DRAIN_CYCLES. On this transition cycle: pc_en=0, ifid_flush=1, idex_flush=1, HALT advances into EX/MEM.
- DRAIN:
  - pc_en=0, ifid_flush=1, idex_flush=1.
  - dstall freezes EX/MEM and MEM/WB and holds the counter; otherwise the counter decrements.
  - Counter reaching 0 (transition from 1) -> HALTED.
  - Mispredict and load-use are ignored, because older stages hold only bubbles.
- HALTED: halt=1, all freezes=1, pc_en=0. Exits only through reset.
- Simultaneous ex_halt with dstall: stay in RUN, frozen; transition on the first cycle dstall drops.
- Reset mid-DRAIN or mid-HALTED returns immediately to RUN with counters cleared.
- idex_rt==0 never stalls.

Decomposition:
- Shared package cpu_types_pkg gains:
  - ctrl_state_t enum {RUN, DRAIN, HALTED};
  - regbits_t (5-bit register index), if not already present.
- One natural sub-module: hazard_detect (pure combinational load-use compare), instantiated once.
- FSM, priority encoder and counters stay in pipeline_ctrl.

Test Plan:
- Reset then ihit=1, no hazards -> pc_en=1, all freeze/flush=0, branch_cnt=0, halt=0.
- exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles with all freezes=1 and pc_en=0; the 4th cycle advances normally.
- idex_dREN=1, idex_rt=5, ifid_rs=5 -> pc_en=0, ifid_freeze=1, idex_flush=1. Repeat with idex_rt=0 -> no stall.
- ex_br_valid=1, ex_mispredict=1, ihit=0 -> redirect=1, pc_en=1, ifid_flush=idex_flush=1, mispredict_cnt 0->1, branch_cnt 0->1. Same pulse with dstall=1 -> counters unchanged, redirect=0.
- ex_halt=1 -> DRAIN; halt asserts exactly 2 non-stalled cycles later. Insert one dstall cycle during DRAIN -> halt delayed by 1. Then pulse nRST low -> halt=0, state RUN.
- Preload branch_cnt near saturation via force (CNT_W=4, value 15), apply ex_br_valid -> stays 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core control path: register indices and sequencer states.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALTED
   } ctrl_state_t;

   localparam int DRAIN_CNT_W = 2;
   typedef logic [DRAIN_CNT_W-1:0] drain_cnt_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
// Purely combinational; register 0 is hardwired to zero so it never creates a hazard.
module hazard_detect
   import cpu_types_pkg::*;
(
   input  logic     idex_dREN,
   input  regbits_t idex_rt,
   input  regbits_t ifid_rs,
   input  regbits_t ifid_rt,
   input  logic     ifid_uses_rt,
   output logic     load_use
);

   always_comb begin
      load_use = idex_dREN && (idex_rt != '0) &&
                 ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-cycle advance/freeze/flush strobes, PC enable, halt draining, branch stats.
// Strobes are combinational from state and inputs; dcache stall freezes the whole pipe.
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exmem_dREN,
   input  logic             exmem_dWEN,
   input  logic             idex_dREN,
   input  regbits_t         idex_rt,
   input  regbits_t         ifid_rs,
   input  regbits_t         ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             ex_br_valid,
   input  logic             ex_mispredict,
   input  logic             ex_halt,
   output logic             pc_en,
   output logic             redirect,
   output logic             ifid_freeze,
   output logic             idex_freeze,
   output logic             exmem_freeze,
   output logic             memwb_freeze,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             halt,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam drain_cnt_t       DRAIN_INIT = drain_cnt_t'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = 1;

   ctrl_state_t state;
   drain_cnt_t  drain_cnt;
   logic        dstall;
   logic        load_use;

   assign dstall = (exmem_dREN | exmem_dWEN) & ~dhit;

   hazard_detect u_hazard_detect (
      .idex_dREN    (idex_dREN),
      .idex_rt      (idex_rt),
      .ifid_rs      (ifid_rs),
      .ifid_rt      (ifid_rt),
      .ifid_uses_rt (ifid_uses_rt),
      .load_use     (load_use)
   );

   always_comb begin
      pc_en        = 1'b0;
      redirect     = 1'b0;
      ifid_freeze  = 1'b0;
      idex_freeze  = 1'b0;
      exmem_freeze = 1'b0;
      memwb_freeze = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      unique case (state)
         RUN: begin
            if (dstall) begin
               ifid_freeze  = 1'b1;
               idex_freeze  = 1'b1;
               exmem_freeze = 1'b1;
               memwb_freeze = 1'b1;
            end else if (ex_halt) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (ex_br_valid && ex_mispredict) begin
               // Stale fetch is abandoned, so ihit does not gate the redirect.
               redirect   = 1'b1;
               pc_en      = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (load_use) begin
               ifid_freeze = 1'b1;
               idex_flush  = 1'b1;
            end else if (!ihit) begin
               ifid_flush = 1'b1;
            end else begin
               pc_en = 1'b1;
            end
         end
         DRAIN: begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_freeze = dstall;
            memwb_freeze = dstall;
         end
         HALTED: begin
            ifid_freeze  = 1'b1;
            idex_freeze  = 1'b1;
            exmem_freeze = 1'b1;
            memwb_freeze = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state          <= RUN;
         drain_cnt      <= '0;
         halt           <= 1'b0;
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (!dstall) begin
                  if (ex_br_valid && (branch_cnt != '1))
                     branch_cnt <= branch_cnt + CNT_ONE;
                  if (ex_br_valid && ex_mispredict && (mispredict_cnt != '1))
                     mispredict_cnt <= mispredict_cnt + CNT_ONE;
                  if (ex_halt) begin
                     state     <= DRAIN;
                     drain_cnt <= DRAIN_INIT;
                  end
               end
            end
            DRAIN: begin
               if (!dstall) begin
                  // A zero count also terminates so a zero-length drain cannot hang.
                  if (drain_cnt <= drain_cnt_t'(1)) begin
                     state     <= HALTED;
                     halt      <= 1'b1;
                     drain_cnt <= '0;
                  end else begin
                     drain_cnt <= drain_cnt - drain_cnt_t'(1);
                  end
               end
            end
            HALTED: ;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, hand sequences, randomized run vs. reference model.
module tb_pipeline_ctrl;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   typedef struct packed {
      logic       ihit;
      logic       dhit;
      logic       exmem_dREN;
      logic       exmem_dWEN;
      logic       idex_dREN;
      logic [4:0] idex_rt;
      logic [4:0] ifid_rs;
      logic [4:0] ifid_rt;
      logic       ifid_uses_rt;
      logic       ex_br_valid;
      logic       ex_mispredict;
      logic       ex_halt;
   } in_t;

   // Output vector order: pc_en redirect fz_ifid fz_idex fz_exmem fz_memwb fl_ifid fl_idex fl_exmem halt
   typedef struct {
      in_t        i;
      logic [9:0] o;
      int         br;
      int         mp;
   } vec_t;

   localparam logic [9:0] O_RUN   = 10'b1000000000;
   localparam logic [9:0] O_NOI   = 10'b0000001000;
   localparam logic [9:0] O_DST   = 10'b0011110000;
   localparam logic [9:0] O_LU    = 10'b0010000100;
   localparam logic [9:0] O_MISP  = 10'b1100001100;
   localparam logic [9:0] O_FLUSH = 10'b0000001100;
   localparam logic [9:0] O_DRST  = 10'b0000111100;
   localparam logic [9:0] O_HALT  = 10'b0011110001;

   logic CLK = 1'b0;
   logic nRST;
   in_t  cur;
   logic pc_en, redirect, ifid_freeze, idex_freeze, exmem_freeze, memwb_freeze;
   logic ifid_flush, idex_flush, exmem_flush, halt;
   logic [CNT_W-1:0] branch_cnt, mispredict_cnt;
   logic [9:0] dut_o;

   int checks = 0;
   int errors = 0;

   // Reference model state: 0 running, 1 draining, 2 halted
   int m_mode, m_left, m_br, m_mp;

   always #5 CLK = ~CLK;

   assign dut_o = {pc_en, redirect, ifid_freeze, idex_freeze, exmem_freeze, memwb_freeze,
                   ifid_flush, idex_flush, exmem_flush, halt};

   pipeline_ctrl #(.DRAIN_CYCLES(2), .CNT_W(CNT_W)) dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .ihit           (cur.ihit),
      .dhit           (cur.dhit),
      .exmem_dREN     (cur.exmem_dREN),
      .exmem_dWEN     (cur.exmem_dWEN),
      .idex_dREN      (cur.idex_dREN),
      .idex_rt        (cur.idex_rt),
      .ifid_rs        (cur.ifid_rs),
      .ifid_rt        (cur.ifid_rt),
      .ifid_uses_rt   (cur.ifid_uses_rt),
      .ex_br_valid    (cur.ex_br_valid),
      .ex_mispredict  (cur.ex_mispredict),
      .ex_halt        (cur.ex_halt),
      .pc_en          (pc_en),
      .redirect       (redirect),
      .ifid_freeze    (ifid_freeze),
      .idex_freeze    (idex_freeze),
      .exmem_freeze   (exmem_freeze),
      .memwb_freeze   (memwb_freeze),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush),
      .exmem_flush    (exmem_flush),
      .halt           (halt),
      .branch_cnt     (branch_cnt),
      .mispredict_cnt (mispredict_cnt)
   );

   function automatic in_t mk(input logic ih, input logic dh, input logic dr, input logic dw,
                              input logic lr, input int rt, input int rs, input int irt,
                              input logic urt, input logic bv, input logic mp, input logic hl);
      in_t v;
      v = '{ihit: ih, dhit: dh, exmem_dREN: dr, exmem_dWEN: dw, idex_dREN: lr,
            idex_rt: 5'(rt), ifid_rs: 5'(rs), ifid_rt: 5'(irt), ifid_uses_rt: urt,
            ex_br_valid: bv, ex_mispredict: mp, ex_halt: hl};
      return v;
   endfunction

   function automatic logic [9:0] model_out(input in_t v);
      logic stall, hazard;
      stall  = (v.exmem_dREN || v.exmem_dWEN) && !v.dhit;
      hazard = v.idex_dREN && (v.idex_rt != 0) &&
               (v.idex_rt == v.ifid_rs || (v.ifid_uses_rt && v.idex_rt == v.ifid_rt));
      if (m_mode == 2) return O_HALT;
      if (m_mode == 1) return stall ? O_DRST : O_FLUSH;
      if (stall) return O_DST;
      if (v.ex_halt) return O_FLUSH;
      if (v.ex_br_valid && v.ex_mispredict) return O_MISP;
      if (hazard) return O_LU;
      if (!v.ihit) return O_NOI;
      return O_RUN;
   endfunction

   task automatic model_step(input in_t v);
      logic stall;
      stall = (v.exmem_dREN || v.exmem_dWEN) && !v.dhit;
      if (m_mode == 0 && !stall) begin
         if (v.ex_br_valid) m_br = (m_br < CNT_MAX) ? m_br + 1 : CNT_MAX;
         if (v.ex_br_valid && v.ex_mispredict) m_mp = (m_mp < CNT_MAX) ? m_mp + 1 : CNT_MAX;
         if (v.ex_halt) begin
            m_mode = 1;
            m_left = 2;
         end
      end else if (m_mode == 1 && !stall) begin
         m_left = m_left - 1;
         if (m_left == 0) m_mode = 2;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Entered and left at posedge+1; leaves the pipe idle.
   task automatic do_reset();
      cur  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nRST = 1'b0;
      #2;
      chk("reset_halt", 32'(halt), 32'd0);
      chk("reset_branch_cnt", 32'(branch_cnt), 32'd0);
      chk("reset_mispredict_cnt", 32'(mispredict_cnt), 32'd0);
      @(posedge CLK);
      #1;
      nRST   = 1'b1;
      m_mode = 0;
      m_left = 0;
      m_br   = 0;
      m_mp   = 0;
   endtask

   task automatic cycle(input in_t v, input string name);
      cur = v;
      #3;
      chk({name, "_strobes"}, 32'(dut_o), 32'(model_out(v)));
      @(posedge CLK);
      model_step(v);
      #1;
      chk({name, "_branch_cnt"}, 32'(branch_cnt), 32'(m_br));
      chk({name, "_mispredict_cnt"}, 32'(mispredict_cnt), 32'(m_mp));
   endtask

   // Counts sampled non-halted cycles after entering DRAIN; one optional dcache stall cycle.
   task automatic drain_count(input int stall_at, output int n);
      in_t v;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         v = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         if (k == stall_at) begin
            v.exmem_dREN = 1'b1;
            v.dhit       = 1'b0;
         end
         cur = v;
         #3;
         if (halt === 1'b1) break;
         chk("drain_strobes", 32'(dut_o), 32'(model_out(v)));
         n++;
         @(posedge CLK);
         model_step(v);
         #1;
      end
   endtask

   vec_t tbl[14];
   in_t  v;
   int   n;

   initial begin
      tbl[0]  = '{mk(1,1,0,0,0,0,0,0,0,0,0,0), O_RUN,  0, 0};
      tbl[1]  = '{mk(0,1,0,0,0,0,0,0,0,0,0,0), O_NOI,  0, 0};
      tbl[2]  = '{mk(1,0,1,0,0,0,0,0,0,0,0,0), O_DST,  0, 0};
      tbl[3]  = '{mk(1,0,0,1,0,0,0,0,0,0,0,0), O_DST,  0, 0};
      tbl[4]  = '{mk(1,1,1,0,0,0,0,0,0,0,0,0), O_RUN,  0, 0};
      tbl[5]  = '{mk(1,1,0,0,1,5,5,0,0,0,0,0), O_LU,   0, 0};
      tbl[6]  = '{mk(1,1,0,0,1,0,0,0,1,0,0,0), O_RUN,  0, 0};
      tbl[7]  = '{mk(1,1,0,0,1,7,3,7,1,0,0,0), O_LU,   0, 0};
      tbl[8]  = '{mk(1,1,0,0,1,7,3,7,0,0,0,0), O_RUN,  0, 0};
      tbl[9]  = '{mk(0,1,0,0,0,0,0,0,0,1,1,0), O_MISP, 1, 1};
      tbl[10] = '{mk(1,0,1,0,0,0,0,0,0,1,1,0), O_DST,  1, 1};
      tbl[11] = '{mk(1,1,0,0,0,0,0,0,0,1,0,0), O_RUN,  2, 1};
      tbl[12] = '{mk(1,1,0,0,1,4,4,0,0,1,1,0), O_MISP, 3, 2};
      tbl[13] = '{mk(0,1,0,0,1,9,1,9,1,0,0,0), O_LU,   3, 2};

      cur  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nRST = 1'b0;
      @(posedge CLK);
      #1;
      do_reset();

      for (int k = 0; k < 14; k++) begin
         cur = tbl[k].i;
         #3;
         chk($sformatf("vec%0d_strobes", k), 32'(dut_o), 32'(tbl[k].o));
         @(posedge CLK);
         #1;
         chk($sformatf("vec%0d_branch_cnt", k), 32'(branch_cnt), 32'(tbl[k].br));
         chk($sformatf("vec%0d_mispredict_cnt", k), 32'(mispredict_cnt), 32'(tbl[k].mp));
      end

      // Three dcache-miss cycles, then the hit lets everything advance.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cur = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         #3;
         chk("dmiss_freeze", 32'(dut_o), 32'(O_DST));
         @(posedge CLK);
         #1;
      end
      cur = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      chk("dmiss_release", 32'(dut_o), 32'(O_RUN));
      @(posedge CLK);
      #1;

      // Halt drains in exactly two non-stalled cycles.
      do_reset();
      cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "halt_enter");
      drain_count(-1, n);
      chk("drain_len_plain", 32'(n), 32'd2);
      chk("halted_strobes", 32'(dut_o), 32'(O_HALT));
      @(posedge CLK);
      #1;
      nRST = 1'b0;
      #1;
      chk("async_reset_halt", 32'(halt), 32'd0);
      chk("async_reset_pc_en", 32'(pc_en), 32'd1);
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      // One dcache stall during drain stretches it by a cycle.
      do_reset();
      cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "halt_enter2");
      drain_count(0, n);
      chk("drain_len_stalled", 32'(n), 32'd3);

      // Halt together with a dcache stall waits in RUN; reset mid-drain returns to RUN.
      do_reset();
      cycle(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "halt_dstall");
      cycle(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "halt_after_dstall");
      cur = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      chk("in_drain_strobes", 32'(dut_o), 32'(O_FLUSH));
      do_reset();
      cur = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      chk("after_drain_reset", 32'(dut_o), 32'(O_RUN));
      @(posedge CLK);
      #1;

      // Saturation of both statistics counters.
      do_reset();
      for (int k = 0; k < 18; k++)
         cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "sat");
      chk("sat_branch_cnt", 32'(branch_cnt), 32'(CNT_MAX));
      chk("sat_mispredict_cnt", 32'(mispredict_cnt), 32'(CNT_MAX));

      // Randomized run against the reference model.
      do_reset();
      for (int k = 0; k < 4000; k++) begin
         if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
         v.ihit          = ($urandom_range(0, 7) != 0);
         v.dhit          = ($urandom_range(0, 2) != 0);
         v.exmem_dREN    = ($urandom_range(0, 3) == 0);
         v.exmem_dWEN    = ($urandom_range(0, 5) == 0);
         v.idex_dREN     = ($urandom_range(0, 2) == 0);
         v.idex_rt       = 5'($urandom_range(0, 3));
         v.ifid_rs       = 5'($urandom_range(0, 3));
         v.ifid_rt       = 5'($urandom_range(0, 3));
         v.ifid_uses_rt  = ($urandom_range(0, 1) == 0);
         v.ex_br_valid   = ($urandom_range(0, 3) == 0);
         v.ex_mispredict = v.ex_br_valid && ($urandom_range(0, 1) == 0);
         v.ex_halt       = ($urandom_range(0, 149) == 0);
         cycle(v, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
